edge_debouncer: RTL and testbench
=================================

EDGE_DEBOUNCER -- requirements
Module: edge_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples of a new level required before accepting it; legal range 1 or more.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: depth of the input synchronizer flop chain; legal range 2 or more.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port signal_in, input, 1 bit: raw asynchronous level, e.g. a button or external strobe.
REQ-006 The block SHALL have port level_out, output, 1 bit: debounced level.
REQ-007 The block SHALL have port rising_pulse, output, 1 bit: single-cycle pulse on each accepted 0->1 transition, intended to drive the pulse_in of a downstream pulse extender.
REQ-008 The block SHALL have port falling_pulse, output, 1 bit: single-cycle pulse on each accepted 1->0 transition.

Function
REQ-009 signal_in SHALL pass through a chain of SYNC_STAGES flops; "sampled" is the last stage, and no other logic SHALL read signal_in.
REQ-010 The counter width SHALL be CLOG2(DEBOUNCE_CYCLES), with a minimum of 1 bit; the counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-011 At each clock edge where sampled equals level_out, the counter SHALL clear to 0 and both pulses SHALL be 0 in the following cycle.
REQ-012 At each edge where sampled differs from level_out and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1 and level_out SHALL hold.
REQ-013 At each edge where sampled differs from level_out and the counter equals DEBOUNCE_CYCLES-1, level_out SHALL take sampled and the counter SHALL clear to 0.
REQ-014 On that same edge, rising_pulse (new level 1) or falling_pulse (new level 0) SHALL be set for exactly one cycle.
REQ-015 The effective states SHALL be: STABLE (counter 0, sampled equal to level_out); PENDING (counter above 0 or sampled differing); and ACCEPT, which is the edge of REQ-013.
REQ-016 A single sample matching level_out while PENDING SHALL abort the pending transition: the counter SHALL return to 0 with no pulse.
REQ-017 With DEBOUNCE_CYCLES=1, every change of sampled SHALL be accepted on the first edge it is seen.
REQ-018 Latency SHALL be exact: if signal_in changes before edge 1 and then holds, level_out SHALL change and the pulse SHALL assert after edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-019 The pulse SHALL deassert after the following edge.
REQ-020 rising_pulse and falling_pulse SHALL never be high in the same cycle.
REQ-021 Neither pulse SHALL be high for 2 consecutive cycles.
REQ-022 Outputs SHALL be driven directly from flops, with no combinational path from signal_in.

Reset
REQ-023 While reset is high, the synchronizer chain, counter, level_out, rising_pulse and falling_pulse SHALL all be 0, taking effect asynchronously without a clock edge.
REQ-024 Reset asserted mid-PENDING SHALL discard the pending transition with no pulse emitted.
REQ-025 After reset release, signal_in held high SHALL produce a rising_pulse after SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-026 After reset release, signal_in held low SHALL produce no pulse.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless stated)
REQ-027 Stimulus: release reset, then hold signal_in=1 from before edge 1. Response: rising_pulse high only in the cycle after edge 6; level_out=1 from edge 6 onward; falling_pulse stays 0.
REQ-028 Stimulus: from stable low, a 3-cycle high glitch. Response: level_out stays 0, no pulse, counter back to 0 after the glitch.
REQ-029 Stimulus: from stable low, 3 cycles high, then 1 cycle low, then held high. Response: no pulse for the first burst; rising_pulse arrives 6 edges after the final rise.
REQ-030 Stimulus: from stable high, signal_in=0 held. Response: falling_pulse high for one cycle after edge 6; level_out=0; rising_pulse stays 0.
REQ-031 Stimulus: assert reset asynchronously between edges while the counter is 2. Response: all outputs 0 immediately; after release with signal_in=1, rising_pulse after edge 6.
REQ-032 Stimulus: DEBOUNCE_CYCLES=1, SYNC_STAGES=2, a 1-cycle high pulse on signal_in. Response: rising_pulse after edge 3, then falling_pulse after edge 4.

Source files
------------

// File: rtl/edge_debouncer.sv
// edge_debouncer: synchronizes a raw level, accepts it after DEBOUNCE_CYCLES stable samples, and emits one-cycle edge pulses
module edge_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic signal_in,
  output logic level_out,
  output logic rising_pulse,
  output logic falling_pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level, r_rise, r_fall;
  logic                   w_sampled, w_diff, w_accept;
  assign w_sampled = r_sync[SYNC_STAGES-1];
  assign w_diff    = w_sampled != r_level;
  assign w_accept  = w_diff && (r_cnt == LAST);
  // A matching sample clears the count, so any bounce restarts the qualification window
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], signal_in};
      r_cnt   <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
      r_level <= w_accept ? w_sampled : r_level;
      r_rise  <= w_accept && w_sampled;
      r_fall  <= w_accept && !w_sampled;
    end
  assign level_out     = r_level;
  assign rising_pulse  = r_rise;
  assign falling_pulse = r_fall;
endmodule

// File: tb/tb_edge_debouncer.sv
// tb_edge_debouncer: directed stimulus pushes expected pulses into queues; negedge monitors pop and compare
module tb_edge_debouncer;
  typedef struct {logic rise; int cyc;} exp_t;
  logic clock = 1'b0, reset, sig, sig2;
  logic lv, rp, fp, lv2, rp2, fp2;
  logic prp = 1'b0, pfp = 1'b0, prp2 = 1'b0, pfp2 = 1'b0;
  int ec = 0, n_checks = 0, n_fail = 0, b;
  exp_t q1[$], q2[$], e1, e2;

  edge_debouncer dut (.clock(clock), .reset(reset), .signal_in(sig), .level_out(lv), .rising_pulse(rp), .falling_pulse(fp));
  edge_debouncer #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) dut2 (.clock(clock), .reset(reset), .signal_in(sig2), .level_out(lv2), .rising_pulse(rp2), .falling_pulse(fp2));

  always #5 clock = ~clock;
  always @(posedge clock) ec++;

  task automatic chk(input string n, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", n, act, exp, ec);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (rp || fp) begin
      chk("d1_excl", int'(rp && fp), 0);
      chk("d1_consec", int'((rp && prp) || (fp && pfp)), 0);
      if (q1.size() == 0) chk("d1_unexpected_pulse", int'({rp, fp}), 0);
      else begin
        e1 = q1.pop_front();
        chk("d1_kind", int'(rp), int'(e1.rise));
        chk("d1_cycle", ec, e1.cyc);
        chk("d1_level", int'(lv), int'(e1.rise));
      end
    end
    if (rp2 || fp2) begin
      chk("d2_excl", int'(rp2 && fp2), 0);
      chk("d2_consec", int'((rp2 && prp2) || (fp2 && pfp2)), 0);
      if (q2.size() == 0) chk("d2_unexpected_pulse", int'({rp2, fp2}), 0);
      else begin
        e2 = q2.pop_front();
        chk("d2_kind", int'(rp2), int'(e2.rise));
        chk("d2_cycle", ec, e2.cyc);
        chk("d2_level", int'(lv2), int'(e2.rise));
      end
    end
    prp = rp; pfp = fp; prp2 = rp2; pfp2 = fp2;
  end

  initial begin
    reset = 1'b1; sig = 1'b0; sig2 = 1'b0;
    #2;
    chk("reset_outputs", int'({lv, rp, fp, lv2, rp2, fp2}), 0);
    tick(3);
    // held high from release: rise after edge 6
    reset = 1'b0; sig = 1'b1; b = ec;
    q1.push_back('{1'b1, b + 6});
    tick(10);
    chk("hold_high_level", int'(lv), 1);
    // debounce of 1: one-cycle input pulse
    sig2 = 1'b1; b = ec;
    q2.push_back('{1'b1, b + 3});
    q2.push_back('{1'b0, b + 4});
    tick(1);
    sig2 = 1'b0;
    tick(8);
    chk("d2_level_after", int'(lv2), 0);
    // falling from stable high
    sig = 1'b0; b = ec;
    q1.push_back('{1'b0, b + 6});
    tick(10);
    chk("fall_level", int'(lv), 0);
    // 3-cycle glitch rejected
    sig = 1'b1;
    tick(3);
    sig = 1'b0;
    tick(4);
    chk("glitch_cnt", int'(dut.r_cnt), 0);
    chk("glitch_level", int'(lv), 0);
    tick(4);
    // 3 high, 1 low, then held high
    sig = 1'b1;
    tick(3);
    sig = 1'b0;
    tick(1);
    sig = 1'b1;
    q1.push_back('{1'b1, ec + 6});
    tick(10);
    chk("retry_level", int'(lv), 1);
    // async reset while counter is 2
    sig = 1'b0;
    tick(4);
    chk("pending_cnt", int'(dut.r_cnt), 2);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_outputs", int'({lv, rp, fp}), 0);
    chk("async_reset_cnt", int'(dut.r_cnt), 0);
    tick(2);
    reset = 1'b0; sig = 1'b1;
    q1.push_back('{1'b1, ec + 6});
    tick(10);
    chk("post_reset_level", int'(lv), 1);
    // held low after reset: no pulse
    reset = 1'b1; sig = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(12);
    chk("low_hold_level", int'(lv), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
